// File: rtl/ssp_sync_bank_if.sv
// Signal bundle between the SSPCLK-side synchroniser bank and its users.
// The master side drives the foreign-domain levels; the slave side is the bank.
interface ssp_sync_bank_if #(
    parameter int NUM_CH = 11
);
    logic [NUM_CH-1:0] AsyncIn;
    logic [NUM_CH-1:0] SyncOut;
    logic [NUM_CH-1:0] RisePulse;
    logic [NUM_CH-1:0] FallPulse;
    logic              AnyChange;

    modport master (
        output AsyncIn,
        input  SyncOut,
        input  RisePulse,
        input  FallPulse,
        input  AnyChange
    );

    modport slave (
        input  AsyncIn,
        output SyncOut,
        output RisePulse,
        output FallPulse,
        output AnyChange
    );
endinterface

// File: rtl/ssp_sync_bank.sv
// Bank of multi-stage synchronisers into SSPCLK with optional per-channel
// glitch filter and edge-pulse generation.
module ssp_sync_bank #(
    parameter int              NUM_CH   = 11,
    parameter int              STAGES   = 2,
    parameter logic [NUM_CH-1:0] RST_VAL  = 11'h010,
    parameter logic [NUM_CH-1:0] FILT_EN  = 11'h000,
    parameter int              FILT_LEN = 3,
    parameter logic [NUM_CH-1:0] EDGE_EN  = 11'h030
) (
    input  logic             SSPCLK,
    input  logic             SSPRST,
    ssp_sync_bank_if.slave   bus
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("ssp_sync_bank: STAGES must be in 2..4");
    end
    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("ssp_sync_bank: FILT_LEN must be in 1..15");
    end
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("ssp_sync_bank: NUM_CH must be in 1..32");
    end

    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    logic [NUM_CH-1:0] stage_q [STAGES];
    logic [NUM_CH-1:0] tail;
    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] hist_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;

    always_ff @(posedge SSPCLK) begin
        if (SSPRST) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= bus.AsyncIn;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tail = stage_q[STAGES-1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (FILT_EN[i]) begin : g_filt
            logic [3:0] cnt_q;
            logic       out_q;

            // A change is accepted only after FILT_LEN consecutive disagreeing cycles.
            always_ff @(posedge SSPCLK) begin
                if (SSPRST) begin
                    out_q <= RST_VAL[i];
                    cnt_q <= 4'd0;
                end else if (tail[i] == out_q) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q == FILT_LAST) begin
                    out_q <= ~out_q;
                    cnt_q <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end

            assign sync_out[i] = out_q;
        end else begin : g_pass
            assign sync_out[i] = tail[i];
        end
    end

    always_ff @(posedge SSPCLK) begin
        if (SSPRST) begin
            hist_q <= RST_VAL;
        end else begin
            hist_q <= sync_out;
        end
    end

    // Both operands are flop outputs, so the pulses carry no path from AsyncIn.
    assign rise = EDGE_EN & sync_out & ~hist_q;
    assign fall = EDGE_EN & ~sync_out & hist_q;

    assign bus.SyncOut   = sync_out;
    assign bus.RisePulse = rise;
    assign bus.FallPulse = fall;
    assign bus.AnyChange = |(rise | fall);

endmodule

// File: tb/tb_ssp_sync_bank.sv
// Directed bench for ssp_sync_bank with a history-based reference model
// checked every cycle after the first reset edge.
module tb_ssp_sync_bank;

    localparam int          NUM_CH   = 11;
    localparam int          STAGES   = 3;
    localparam int          FILT_LEN = 3;
    localparam logic [10:0] RST_VAL  = 11'h010;
    localparam logic [10:0] FILT_EN  = 11'h004;
    localparam logic [10:0] EDGE_EN  = 11'h031;

    logic SSPCLK = 1'b0;
    logic SSPRST = 1'b1;

    ssp_sync_bank_if #(.NUM_CH(NUM_CH)) bus ();

    ssp_sync_bank #(
        .NUM_CH  (NUM_CH),
        .STAGES  (STAGES),
        .RST_VAL (RST_VAL),
        .FILT_EN (FILT_EN),
        .FILT_LEN(FILT_LEN),
        .EDGE_EN (EDGE_EN)
    ) dut (
        .SSPCLK(SSPCLK),
        .SSPRST(SSPRST),
        .bus   (bus)
    );

    always #5 SSPCLK = ~SSPCLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the tail is the input sampled STAGES-1 edges ago unless a
    // reset fell inside that window; filtered outputs flip after FILT_LEN
    // consecutive disagreeing cycles; pulses are output changes on enabled bits.
    logic [10:0] win_v [STAGES];
    bit          win_r [STAGES] = '{default: 1'b1};
    logic [10:0] m_tail;
    logic [10:0] m_out;
    logic [10:0] m_prev;
    int          run [NUM_CH];
    bit          chk_en = 1'b0;

    always @(posedge SSPCLK) begin : model
        logic [10:0] a;
        logic [10:0] tail_prev;
        logic [10:0] nout;
        logic [10:0] exp_rise;
        logic [10:0] exp_fall;
        bit          r;
        bit          anyr;

        a         = bus.AsyncIn;
        r         = SSPRST;
        tail_prev = m_tail;
        for (int k = STAGES - 1; k > 0; k--) begin
            win_v[k] = win_v[k-1];
            win_r[k] = win_r[k-1];
        end
        win_v[0] = a;
        win_r[0] = r;
        anyr = 1'b0;
        for (int k = 0; k < STAGES; k++) anyr |= win_r[k];
        m_tail = anyr ? RST_VAL : win_v[STAGES-1];

        nout = m_out;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r) begin
                nout[i] = RST_VAL[i];
                run[i]  = 0;
            end else if (FILT_EN[i]) begin
                if (tail_prev[i] === m_out[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == FILT_LEN) begin
                        nout[i] = ~m_out[i];
                        run[i]  = 0;
                    end
                end
            end else begin
                nout[i] = m_tail[i];
            end
        end
        m_prev = r ? RST_VAL : m_out;
        m_out  = nout;
        if (r) chk_en = 1'b1;

        #1;
        if (chk_en) begin
            exp_rise = EDGE_EN & m_out & ~m_prev;
            exp_fall = EDGE_EN & ~m_out & m_prev;
            chk("model_syncout", 32'(bus.SyncOut), 32'(m_out));
            chk("model_rise", 32'(bus.RisePulse), 32'(exp_rise));
            chk("model_fall", 32'(bus.FallPulse), 32'(exp_fall));
            chk("model_any", 32'(bus.AnyChange), 32'(|(exp_rise | exp_fall)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge SSPCLK);
            #2;
        end
    endtask

    initial begin
        bus.AsyncIn = '0;
        SSPRST      = 1'b1;
        cyc(3);
        chk("rst_syncout", 32'(bus.SyncOut), 32'h010);
        chk("rst_rise", 32'(bus.RisePulse), 32'h0);
        chk("rst_fall", 32'(bus.FallPulse), 32'h0);
        chk("rst_any", 32'(bus.AnyChange), 32'h0);

        SSPRST      = 1'b0;
        bus.AsyncIn = 11'h010;
        cyc(10);
        chk("idle_syncout", 32'(bus.SyncOut), 32'h010);
        chk("idle_any", 32'(bus.AnyChange), 32'h0);

        // Unfiltered latency: visible after the third sampling edge
        bus.AsyncIn[0] = 1'b1;
        cyc(1);
        chk("lat_e0", 32'(bus.SyncOut[0]), 32'h0);
        cyc(1);
        chk("lat_e1", 32'(bus.SyncOut[0]), 32'h0);
        cyc(1);
        chk("lat_e2", 32'(bus.SyncOut[0]), 32'h1);
        chk("lat_rise", 32'(bus.RisePulse[0]), 32'h1);
        chk("lat_any", 32'(bus.AnyChange), 32'h1);
        cyc(1);
        chk("lat_rise_end", 32'(bus.RisePulse[0]), 32'h0);
        chk("lat_any_end", 32'(bus.AnyChange), 32'h0);
        bus.AsyncIn[0] = 1'b0;
        cyc(5);

        // Two-cycle glitch on the filtered channel is rejected
        bus.AsyncIn[2] = 1'b1;
        cyc(2);
        bus.AsyncIn[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc(1);
            chk("glitch_sync2", 32'(bus.SyncOut[2]), 32'h0);
        end

        // Sustained level passes after STAGES+FILT_LEN edges
        bus.AsyncIn[2] = 1'b1;
        cyc(5);
        chk("filt_e4", 32'(bus.SyncOut[2]), 32'h0);
        cyc(1);
        chk("filt_e5", 32'(bus.SyncOut[2]), 32'h1);
        chk("filt_no_rise", 32'(bus.RisePulse[2]), 32'h0);
        bus.AsyncIn[2] = 1'b0;
        cyc(8);
        chk("filt_back_low", 32'(bus.SyncOut[2]), 32'h0);

        // Reset lands while the filter counter is at FILT_LEN-1
        bus.AsyncIn[2] = 1'b1;
        cyc(5);
        SSPRST = 1'b1;
        cyc(1);
        chk("rstf_sync2", 32'(bus.SyncOut[2]), 32'h0);
        chk("rstf_any", 32'(bus.AnyChange), 32'h0);
        SSPRST         = 1'b0;
        bus.AsyncIn[2] = 1'b0;
        cyc(8);

        // Frame-select channel fall then rise, five cycles apart
        bus.AsyncIn[4] = 1'b0;
        cyc(3);
        chk("fs_fall", 32'(bus.FallPulse[4]), 32'h1);
        chk("fs_sync4", 32'(bus.SyncOut[4]), 32'h0);
        cyc(1);
        chk("fs_fall_end", 32'(bus.FallPulse[4]), 32'h0);
        cyc(1);
        bus.AsyncIn[4] = 1'b1;
        cyc(3);
        chk("fs_rise", 32'(bus.RisePulse[4]), 32'h1);
        chk("fs_fall_none", 32'(bus.FallPulse[4]), 32'h0);
        cyc(3);

        // Simultaneous transitions; bit 1 has no edge detection
        bus.AsyncIn[4] = 1'b0;
        bus.AsyncIn[5] = 1'b1;
        bus.AsyncIn[1] = 1'b1;
        cyc(3);
        chk("sim_fall4", 32'(bus.FallPulse[4]), 32'h1);
        chk("sim_rise5", 32'(bus.RisePulse[5]), 32'h1);
        chk("sim_any", 32'(bus.AnyChange), 32'h1);
        chk("sim_sync1", 32'(bus.SyncOut[1]), 32'h1);
        chk("sim_rise1", 32'(bus.RisePulse[1]), 32'h0);
        cyc(1);
        chk("sim_any_end", 32'(bus.AnyChange), 32'h0);

        repeat (60) begin
            bus.AsyncIn = 11'($urandom);
            cyc(1);
        end
        cyc(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssp_sync_bank.md
Name: ssp_sync_bank

Overview:
- Parametrised bank of multi-stage synchronisers that brings NUM_CH asynchronous or foreign-domain single-bit signals into the SSPCLK domain.
- Successor to the fixed two-flop SSPCLK-side synchroniser set. Adds configurable depth, per-channel reset values, an optional per-channel glitch filter and per-channel edge-pulse outputs.
- Sits between the PCLK register block / SSP pins and the prescaler, TxRx and interrupt logic.

Parameters:
- NUM_CH, 11, number of channels (1-32).
- STAGES, 2, synchroniser flops per channel (2-4).
- RST_VAL, 11'h010, per-channel reset value of every stage, filter output and edge history (bit 4 = frame-select input, idles high).
- FILT_EN, 11'h000, per-channel glitch-filter enable mask.
- FILT_LEN, 3, consecutive stable cycles required by filtered channels (1-15).
- EDGE_EN, 11'h030, per-channel enable for rise/fall pulse generation.

Ports:
- SSPCLK  input  1  SSP clock; all state on its rising edge.
- SSPRST  input  1  synchronous, active-high reset.
- AsyncIn  input  NUM_CH  signals from PCLK domain or pins.
- SyncOut  output  NUM_CH  synchronised (and, where enabled, filtered) level.
- RisePulse  output  NUM_CH  one-cycle pulse on a 0->1 transition of SyncOut.
- FallPulse  output  NUM_CH  one-cycle pulse on a 1->0 transition of SyncOut.
- AnyChange  output  1  OR of (RisePulse | FallPulse) across all channels.

Behaviour:
- Clock and reset are decided: one clock, SSPCLK. Reset SSPRST is synchronous and active-high.
- Reset applies when SSPRST=1 at a SSPCLK rising edge. Per channel i:
  - every sync stage, SyncOut[i] and edge history register loaded with RST_VAL[i];
  - filter counter cleared to 0;
  - RisePulse=FallPulse=0 and AnyChange=0 in the cycle after reset.
- Reset asserted mid-operation overrides everything on that edge, including a pending filter flip.
- Sync chain: stage0 <= AsyncIn[i]; stage(k) <= stage(k-1); chain tail is stage(STAGES-1). No combinational path from AsyncIn to any output.
- Unfiltered channel (FILT_EN[i]=0): SyncOut[i] = tail. Latency is STAGES edges from the first edge that samples the new level.
- Filtered channel (FILT_EN[i]=1):
  - SyncOut[i] is a register; counter width is 4 bits.
  - If tail == SyncOut[i], the counter clears to 0.
  - If tail != SyncOut[i] and counter == FILT_LEN-1, SyncOut[i] toggles and the counter clears.
  - Otherwise the counter increments.
  - Latency is STAGES+FILT_LEN edges for a stable input.
  - Any return of tail to SyncOut within FILT_LEN cycles aborts the change with no output toggle.
- Edge history: hist[i] <= SyncOut[i] every cycle.
  - RisePulse[i] = EDGE_EN[i] & SyncOut[i] & ~hist[i].
  - FallPulse[i] = EDGE_EN[i] & ~SyncOut[i] & hist[i].
  - Pulses are driven from registers only (glitch-free) and last exactly one cycle, coincident with the first cycle of the new SyncOut level.
  - Channels with EDGE_EN[i]=0 hold both pulse outputs at 0.
- AnyChange is combinational OR of all pulse bits; it is 0 whenever no enabled channel transitions.
- Toggles faster than the sync chain (input width < 1 SSPCLK period) may be lost. This is legal; the bank never produces a pulse without a SyncOut change.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Parameter checks: STAGES outside 2-4, FILT_LEN outside 1-15 or NUM_CH outside 1-32 is an elaboration error.

Test Plan:
- Reset values, defaults: hold SSPRST=1 for 3 cycles with AsyncIn=0 -> SyncOut=11'h010, all pulses 0. Release with AsyncIn=11'h010 -> SyncOut stays 11'h010 and no pulses for 10 cycles.
- Latency, STAGES=3: step AsyncIn[0] 0->1 before edge N -> SyncOut[0]=1 from edge N+2 (third sampling edge). With EDGE_EN[0]=1, RisePulse[0] and AnyChange high for exactly that one cycle.
- Filter, FILT_EN[2]=1, FILT_LEN=3:
  - 2-cycle high glitch on AsyncIn[2] -> SyncOut[2] never leaves 0, no pulses.
  - Sustained high -> SyncOut[2]=1 at STAGES+3 edges after the first sampling edge.
- Frame-select channel (bit 4, resets high): drive AsyncIn[4] 1->0->1 with 5-cycle spacing -> FallPulse[4] one cycle, then RisePulse[4] one cycle, 5 cycles apart.
- Reset mid-filter: assert SSPRST while channel 2's counter=2 and tail differs -> next cycle SyncOut[2]=RST_VAL[2], counter 0, no pulse.
- Simultaneous events: toggle bits 4 and 5 on the same edge -> Rise/Fall pulses on both channels in the same cycle, AnyChange one cycle. Bit 1 toggle with EDGE_EN[1]=0 -> SyncOut[1] follows, pulses stay 0.
